serial_tx_arbiter: RTL and testbench

SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

---
 rtl/serial_tx_arbiter_if.sv | 29 ++
 rtl/serial_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_serial_tx_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_tx_arbiter_if.sv
// Purpose: bundles the requester-side request/payload bus and the shared serial line outputs.
// Latency: none, signal container only.
// Backpressure: requesters hold req until their grant bit is seen; the arbiter never stalls the line.
interface serial_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] data_flat;
    logic        serial_out;
    logic [3:0]  grant;
    logic        busy;
    logic        done;

    modport master (
        output req,
        output data_flat,
        input  serial_out,
        input  grant,
        input  busy,
        input  done
    );

    modport slave (
        input  req,
        input  data_flat,
        output serial_out,
        output grant,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Purpose: round-robin arbiter serialising one 12-bit frame (start, id, payload, stop) per grant.
// Latency: START is driven the cycle after an IDLE edge sees req; frames are 12 cycles plus 1 idle.
// Backpressure: req/data are only sampled in IDLE; losers stay pending and must hold req until granted.
module serial_tx_arbiter (
    input  logic              clk,
    input  logic              rst,
    serial_tx_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        ID,
        DATA,
        STOP
    } state_t;

    state_t      state;
    logic [1:0]  ptr;
    logic [2:0]  bit_cnt;
    logic [7:0]  payload;
    logic [1:0]  id;

    logic        serial_q;
    logic [3:0]  grant_q;
    logic        busy_q;
    logic        done_q;

    logic        win_vld;
    logic [1:0]  win_id;
    logic [2:0]  bit_cnt_nxt;

    assign bus.serial_out = serial_q;
    assign bus.grant      = grant_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    // Counter advance; wrapping 7 -> 0 marks the last payload bit, and the
    // inverted count indexes the payload MSB first.
    assign bit_cnt_nxt = bit_cnt + 3'd1;

    // Round-robin search starting at ptr, first set request bit wins.
    always_comb begin
        logic [1:0] cand;
        win_vld = 1'b0;
        win_id  = ptr;
        cand    = ptr;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!win_vld && bus.req[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    // Frame FSM; outputs are computed for the state being entered so they are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            bit_cnt  <= 3'd0;
            payload  <= 8'd0;
            id       <= 2'd0;
            serial_q <= 1'b1;
            grant_q  <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    serial_q <= 1'b1;
                    grant_q  <= 4'd0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    if (win_vld) begin
                        id       <= win_id;
                        payload  <= bus.data_flat[{win_id, 3'b000} +: 8];
                        ptr      <= win_id + 2'd1;
                        grant_q  <= 4'b0001 << win_id;
                        serial_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    grant_q  <= 4'd0;
                    serial_q <= id[1];
                    bit_cnt  <= 3'd0;
                    state    <= ID;
                end
                ID: begin
                    // bit_cnt 0: id[1] on the line, 1: id[0] on the line.
                    if (bit_cnt == 3'd0) begin
                        serial_q <= id[0];
                        bit_cnt  <= 3'd1;
                    end else begin
                        serial_q <= payload[7];
                        bit_cnt  <= 3'd0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    bit_cnt <= bit_cnt_nxt;
                    if (bit_cnt_nxt == 3'd0) begin
                        serial_q <= 1'b1;
                        done_q   <= 1'b1;
                        state    <= STOP;
                    end else begin
                        serial_q <= payload[~bit_cnt_nxt];
                    end
                end
                STOP: begin
                    serial_q <= 1'b1;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    serial_q <= 1'b1;
                    grant_q  <= 4'd0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Purpose: self-checking bench for serial_tx_arbiter against a frame-list reference model.
// Latency: model predicts outputs for each cycle after every rising edge.
// Backpressure: bench requesters hold req until their grant bit, with occasional drops.
module tb_serial_tx_arbiter;

    logic clk = 1'b0;
    logic rst;

    serial_tx_arbiter_if bus ();

    serial_tx_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a frame is a list of 12 line bits; m_pos is the index
    // of the bit currently on the line, -1 when idle.
    int         m_pos = -1;
    int         m_ptr = 0;
    logic       m_bits [12];
    logic [3:0] m_gnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int  w;
        bit  found;
        logic [7:0] pay;
        if (rst) begin
            m_pos = -1;
            m_ptr = 0;
        end else if (m_pos < 0) begin
            found = 0;
            w = 0;
            for (int i = 0; i < 4; i++) begin
                if (!found && bus.req[(m_ptr + i) % 4]) begin
                    found = 1;
                    w = (m_ptr + i) % 4;
                end
            end
            if (found) begin
                pay = bus.data_flat[8*w +: 8];
                m_bits[0] = 1'b0;
                m_bits[1] = w[1];
                m_bits[2] = w[0];
                for (int j = 0; j < 8; j++) m_bits[3+j] = pay[7-j];
                m_bits[11] = 1'b1;
                m_gnt = 4'(1 << w);
                m_ptr = (w + 1) % 4;
                m_pos = 0;
            end
        end else if (m_pos == 11) begin
            m_pos = -1;
        end else begin
            m_pos++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (m_pos < 0) begin
            check_eq("ser", 32'(bus.serial_out), 32'd1);
            check_eq("busy", 32'(bus.busy), 32'd0);
            check_eq("done", 32'(bus.done), 32'd0);
            check_eq("grant", 32'(bus.grant), 32'd0);
        end else begin
            check_eq("ser", 32'(bus.serial_out), 32'(m_bits[m_pos]));
            check_eq("busy", 32'(bus.busy), 32'd1);
            check_eq("done", 32'(bus.done), (m_pos == 11) ? 32'd1 : 32'd0);
            check_eq("grant", 32'(bus.grant), (m_pos == 0) ? 32'(m_gnt) : 32'd0);
        end
    endtask

    task automatic wait_grant(output logic [3:0] g);
        int n = 0;
        step();
        while (bus.grant == 4'd0 && n < 30) begin
            step();
            n++;
        end
        g = bus.grant;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 20) begin
            step();
            n++;
        end
        check_eq("idle_to", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [11:0] seq;
        logic [7:0]  dbits;
        logic [3:0]  g;
        logic [3:0]  gl [5];
        int          tl [5];
        int          ng;
        int          cnt;
        logic        s1, s0;
        logic [3:0]  pend;

        rst = 1'b1;
        bus.req = 4'd0;
        bus.data_flat = 32'd0;
        step();
        step();
        check_eq("rst_ser", 32'(bus.serial_out), 32'd1);
        check_eq("rst_grant", 32'(bus.grant), 32'd0);
        rst = 1'b0;
        step();

        // Single request, requester 1 with 0xA5.
        bus.data_flat = 32'h0000_A500;
        bus.req = 4'b0010;
        step();
        check_eq("single_grant", 32'(bus.grant), 32'h2);
        bus.req = 4'b0000;
        seq[11] = bus.serial_out;
        cnt = (bus.done) ? 1 : 0;
        for (int k = 1; k < 12; k++) begin
            step();
            seq[11-k] = bus.serial_out;
            if (bus.done) cnt += (k == 11) ? 1 : 100;
        end
        check_eq("single_seq", 32'(seq), 32'h34B);
        check_eq("single_done", 32'(cnt), 32'd1);
        step();
        check_eq("single_idle", 32'(bus.serial_out), 32'd1);

        // Contention from a fresh reset, all four requesting.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req = 4'hF;
        bus.data_flat = $urandom;
        ng = 0;
        for (int c = 0; c < 80 && ng < 5; c++) begin
            step();
            if (bus.grant != 4'd0) begin
                gl[ng] = bus.grant;
                tl[ng] = c;
                ng++;
            end
        end
        check_eq("cont_count", 32'(ng), 32'd5);
        check_eq("cont_first_t", 32'(tl[0]), 32'd0);
        check_eq("cont_g0", 32'(gl[0]), 32'h1);
        check_eq("cont_g1", 32'(gl[1]), 32'h2);
        check_eq("cont_g2", 32'(gl[2]), 32'h4);
        check_eq("cont_g3", 32'(gl[3]), 32'h8);
        check_eq("cont_g4", 32'(gl[4]), 32'h1);
        for (int i = 1; i < 5; i++) check_eq("cont_gap", 32'(tl[i] - tl[i-1]), 32'd13);
        bus.req = 4'd0;
        wait_idle();

        // Pointer wrap: serve requester 3, then 0 beats 3.
        bus.req = 4'b1000;
        wait_grant(g);
        check_eq("wrap_g3", 32'(g), 32'h8);
        bus.req = 4'd0;
        wait_idle();
        bus.req = 4'b1001;
        wait_grant(g);
        check_eq("wrap_g0", 32'(g), 32'h1);
        bus.req = 4'd0;
        wait_idle();

        // Reset on the 4th payload bit.
        bus.data_flat = $urandom;
        bus.req = 4'b0001;
        wait_grant(g);
        bus.req = 4'd0;
        for (int k = 0; k < 6; k++) step();
        rst = 1'b1;
        step();
        check_eq("rst_mid_ser", 32'(bus.serial_out), 32'd1);
        check_eq("rst_mid_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (bus.done) cnt++;
        end
        check_eq("rst_mid_nodone", 32'(cnt), 32'd0);
        bus.req = 4'b0100;
        wait_grant(g);
        check_eq("rst_mid_g", 32'(g), 32'h4);
        bus.req = 4'd0;
        step();
        s1 = bus.serial_out;
        step();
        s0 = bus.serial_out;
        check_eq("rst_mid_id", 32'({s1, s0}), 32'h2);
        wait_idle();

        // Payload isolation after latching.
        bus.data_flat = 32'h0000_00FF;
        bus.req = 4'b0001;
        wait_grant(g);
        bus.data_flat = 32'd0;
        bus.req = 4'd0;
        step();
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            dbits[7-k] = bus.serial_out;
        end
        check_eq("iso_data", 32'(dbits), 32'hFF);
        wait_idle();

        // Request raised and dropped during a frame is lost.
        bus.req = 4'b0010;
        wait_grant(g);
        bus.req = 4'd0;
        for (int k = 0; k < 3; k++) step();
        bus.req = 4'b0001;
        for (int k = 0; k < 4; k++) step();
        bus.req = 4'd0;
        wait_idle();
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (bus.grant != 4'd0 || bus.serial_out != 1'b1) cnt++;
        end
        check_eq("late_lost", 32'(cnt), 32'd0);

        // Randomised traffic with hold-until-grant requesters, drops and rare resets.
        pend = 4'd0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(399) == 0);
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(5) == 0) pend[i] = 1'b1;
                else if (pend[i] && $urandom_range(79) == 0) pend[i] = 1'b0;
            end
            bus.req = pend;
            bus.data_flat = $urandom;
            step();
            pend = pend & ~bus.grant;
        end
        rst = 1'b0;
        bus.req = 4'd0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
